// File: rtl/conn_table_reader.sv
// Read side of the connection table: fetches a stored 4-tuple by ID, or scans
// forward (with wrap) from an ID for the next valid entry.
module conn_table_reader #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              cr_clk,
    input  logic              cr_rst_n,
    input  logic              cr_req,
    input  logic              cr_mode,
    input  logic [ADDR_W-1:0] cr_id_in,
    output logic              cr_busy,
    output logic              cr_done,
    output logic [7:0]        cr_error,
    output logic [ADDR_W-1:0] cr_id_out,
    output logic [23:0]       cr_mac_src,
    output logic [23:0]       cr_mac_dst,
    output logic [31:0]       cr_ip_src,
    output logic [31:0]       cr_ip_dst,
    output logic [15:0]       cr_port_src,
    output logic [15:0]       cr_port_dst,
    output logic [ADDR_W-1:0] cr_ram_addr,
    output logic              cr_ram_rden,
    input  logic [144:0]      cr_ram_q
);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ID   = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        WAIT_LAST = 2'(RAM_LAT - 1);

    localparam logic [7:0] ERR_OK      = 8'h00;
    localparam logic [7:0] ERR_INVALID = 8'h03;
    localparam logic [7:0] ERR_EMPTY   = 8'h04;
    localparam logic [7:0] ERR_RANGE   = 8'h05;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          wait_q, wait_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          error_q, error_d;
    logic [ADDR_W-1:0]   id_out_q, id_out_d;
    logic [143:0]        tuple_q, tuple_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rden_q, rden_d;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        id_out_d = id_out_q;
        tuple_d  = tuple_q;
        addr_d   = addr_q;
        rden_d   = rden_q;

        unique case (state_q)
            // DONE accepts a new request exactly like IDLE (back-to-back)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (cr_req) begin
                    mode_d  = cr_mode;
                    start_d = cr_id_in;
                    cnt_d   = '0;
                    if ({1'b0, cr_id_in} >= DEPTH_X) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        error_d  = ERR_RANGE;
                        id_out_d = cr_id_in;
                        tuple_d  = '0;
                    end else begin
                        state_d = S_ISSUE;
                        busy_d  = 1'b1;
                        rden_d  = 1'b1;
                        addr_d  = cr_id_in;
                    end
                end
            end
            S_ISSUE: begin
                rden_d  = 1'b0;
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) state_d = S_CHECK;
                else                     wait_d  = wait_q + 2'd1;
            end
            S_CHECK: begin
                state_d  = S_DONE;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                id_out_d = addr_q;
                if (cr_ram_q[0]) begin
                    error_d = ERR_OK;
                    tuple_d = cr_ram_q[144:1];
                end else if (!mode_q) begin
                    error_d = ERR_INVALID;
                    tuple_d = '0;
                end else if (cnt_q == LAST_ID) begin
                    error_d  = ERR_EMPTY;
                    id_out_d = start_q;
                    tuple_d  = '0;
                end else begin
                    // miss during a scan: probe the next ID, outputs untouched
                    state_d  = S_ISSUE;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    id_out_d = id_out_q;
                    cnt_d    = cnt_q + 1'b1;
                    rden_d   = 1'b1;
                    addr_d   = (addr_q == LAST_ID) ? '0 : addr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cr_clk or negedge cr_rst_n) begin
        if (!cr_rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            start_q  <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= '0;
            id_out_q <= '0;
            tuple_q  <= '0;
            addr_q   <= '0;
            rden_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            id_out_q <= id_out_d;
            tuple_q  <= tuple_d;
            addr_q   <= addr_d;
            rden_q   <= rden_d;
        end
    end

    assign cr_busy     = busy_q;
    assign cr_done     = done_q;
    assign cr_error    = error_q;
    assign cr_id_out   = id_out_q;
    assign cr_mac_src  = tuple_q[143:120];
    assign cr_mac_dst  = tuple_q[119:96];
    assign cr_ip_src   = tuple_q[95:64];
    assign cr_ip_dst   = tuple_q[63:32];
    assign cr_port_src = tuple_q[31:16];
    assign cr_port_dst = tuple_q[15:0];
    assign cr_ram_addr = addr_q;
    assign cr_ram_rden = rden_q;

endmodule

// File: tb/tb_conn_table_reader.sv
// Directed bench for conn_table_reader: fetch, scan with wrap, empty scan,
// back-to-back requests, async reset mid-scan, and out-of-range IDs.
module tb_conn_table_reader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         mode = 1'b0;
    logic [7:0]   id_in = 8'd0;
    logic         busy, done;
    logic [7:0]   error, id_out;
    logic [23:0]  mac_src, mac_dst;
    logic [31:0]  ip_src, ip_dst;
    logic [15:0]  port_src, port_dst;
    logic [7:0]   ram_addr;
    logic         ram_rden;
    logic [144:0] ram_q = '0;

    logic         busy2, done2;
    logic [7:0]   error2, id_out2;
    logic [23:0]  mac_src2, mac_dst2;
    logic [31:0]  ip_src2, ip_dst2;
    logic [15:0]  port_src2, port_dst2;
    logic [7:0]   ram_addr2;
    logic         ram_rden2;
    logic [144:0] ram_q2 = '0;

    logic [144:0] mem [0:255];

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rden)  ram_q  <= mem[ram_addr];
        if (ram_rden2) ram_q2 <= mem[ram_addr2];
    end

    conn_table_reader #(.DEPTH(256), .ADDR_W(8), .RAM_LAT(1)) u_dut (
        .cr_clk(clk), .cr_rst_n(rst_n), .cr_req(req), .cr_mode(mode), .cr_id_in(id_in),
        .cr_busy(busy), .cr_done(done), .cr_error(error), .cr_id_out(id_out),
        .cr_mac_src(mac_src), .cr_mac_dst(mac_dst), .cr_ip_src(ip_src), .cr_ip_dst(ip_dst),
        .cr_port_src(port_src), .cr_port_dst(port_dst),
        .cr_ram_addr(ram_addr), .cr_ram_rden(ram_rden), .cr_ram_q(ram_q)
    );

    conn_table_reader #(.DEPTH(200), .ADDR_W(8), .RAM_LAT(1)) u_dut200 (
        .cr_clk(clk), .cr_rst_n(rst_n), .cr_req(req), .cr_mode(mode), .cr_id_in(id_in),
        .cr_busy(busy2), .cr_done(done2), .cr_error(error2), .cr_id_out(id_out2),
        .cr_mac_src(mac_src2), .cr_mac_dst(mac_dst2), .cr_ip_src(ip_src2), .cr_ip_dst(ip_dst2),
        .cr_port_src(port_src2), .cr_port_dst(port_dst2),
        .cr_ram_addr(ram_addr2), .cr_ram_rden(ram_rden2), .cr_ram_q(ram_q2)
    );

    function automatic logic [143:0] fields();
        return {mac_src, mac_dst, ip_src, ip_dst, port_src, port_dst};
    endfunction

    function automatic logic [143:0] fields2();
        return {mac_src2, mac_dst2, ip_src2, ip_dst2, port_src2, port_dst2};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request at the falling edge; returns #1 after the accept edge.
    task automatic start_req(input logic m, input logic [7:0] id);
        @(negedge clk);
        req = 1'b1; mode = m; id_in = id;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // Cycles from the current edge until done (sel=1 watches the DEPTH=200 unit).
    task automatic wait_done(input bit sel, input int budget, output int cycles);
        cycles = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if ((sel ? done2 : done) === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[3]   = {24'h111111, 24'h222222, 32'h03030303, 32'h04040404, 16'h0033, 16'h0044, 1'b1};
        mem[5]   = {24'hA1B2C3, 24'h0D0E0F, 32'hC0A80001, 32'hC0A80002, 16'd80, 16'd1234, 1'b1};
        mem[7]   = {24'hDEADBE, 24'hEF0123, 32'h77777777, 32'h88888888, 16'h9999, 16'hAAAA, 1'b0};
        mem[250] = {24'hFAFAFA, 24'hFBFBFB, 32'hFCFCFCFC, 32'hFDFDFDFD, 16'hFEFE, 16'hFFFF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 160'(busy), 160'd0);
        chk("reset_done", 160'(done), 160'd0);
        chk("reset_rden", 160'(ram_rden), 160'd0);
        chk("reset_error", 160'(error), 160'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch valid ID 5
        start_req(1'b0, 8'd5);
        chk("t1_busy", 160'(busy), 160'd1);
        chk("t1_rden", 160'(ram_rden), 160'd1);
        chk("t1_addr", 160'(ram_addr), 160'd5);
        wait_done(1'b0, 20, lat);
        chk("t1_latency", 160'(lat), 160'd3);
        chk("t1_busy_done", 160'(busy), 160'd0);
        chk("t1_error", 160'(error), 160'h00);
        chk("t1_id_out", 160'(id_out), 160'd5);
        chk("t1_fields", 160'(fields()), 160'(144'hA1B2C3_0D0E0F_C0A80001_C0A80002_0050_04D2));
        @(posedge clk); #1;
        chk("t1_done_pulse", 160'(done), 160'd0);

        // Fetch invalid ID 7 (non-zero payload must not leak)
        start_req(1'b0, 8'd7);
        wait_done(1'b0, 20, lat);
        chk("t2_latency", 160'(lat), 160'd3);
        chk("t2_error", 160'(error), 160'h03);
        chk("t2_id_out", 160'(id_out), 160'd7);
        chk("t2_fields", 160'(fields()), 160'd0);

        // Back-to-back: request ID 250 in the done cycle of an ID 3 fetch
        start_req(1'b0, 8'd3);
        wait_done(1'b0, 20, lat);
        chk("t5_first_latency", 160'(lat), 160'd3);
        chk("t5_first_id", 160'(id_out), 160'd3);
        chk("t5_first_fields", 160'(fields()), 160'(144'h111111_222222_03030303_04040404_0033_0044));
        req = 1'b1; mode = 1'b0; id_in = 8'd250;
        @(posedge clk); #1;
        req = 1'b0;
        chk("t5_accepted_busy", 160'(busy), 160'd1);
        wait_done(1'b0, 20, lat);
        chk("t5_second_latency", 160'(lat), 160'd3);
        chk("t5_second_id", 160'(id_out), 160'd250);
        chk("t5_second_fields", 160'(fields()), 160'(144'hFAFAFA_FBFBFB_FCFCFCFC_FDFDFDFD_FEFE_FFFF));

        // Scan from 251 with only 3 and 250 valid: wraps, hits 3 on probe 9
        mem[5][0] = 1'b0;
        start_req(1'b1, 8'd251);
        wait_done(1'b0, 60, lat);
        chk("t3_latency", 160'(lat), 160'd27);
        chk("t3_error", 160'(error), 160'h00);
        chk("t3_id_out", 160'(id_out), 160'd3);
        chk("t3_fields", 160'(fields()), 160'(144'h111111_222222_03030303_04040404_0033_0044));

        // DEPTH=200 unit: out-of-range ID, then a scan that wraps at 199
        start_req(1'b0, 8'd220);
        chk("range_done", 160'(done2), 160'd1);
        chk("range_busy", 160'(busy2), 160'd0);
        chk("range_error", 160'(error2), 160'h05);
        chk("range_id_out", 160'(id_out2), 160'd220);
        chk("range_rden", 160'(ram_rden2), 160'd0);
        start_req(1'b1, 8'd198);
        wait_done(1'b1, 40, lat);
        chk("d200_scan_latency", 160'(lat), 160'd18);
        chk("d200_scan_id", 160'(id_out2), 160'd3);
        chk("d200_scan_fields", 160'(fields2()), 160'(144'h111111_222222_03030303_04040404_0033_0044));

        // Empty table scan from 0, with an ignored request while busy
        for (int i = 0; i < 256; i++) mem[i][0] = 1'b0;
        start_req(1'b1, 8'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        req = 1'b1; mode = 1'b0; id_in = 8'd5;
        @(posedge clk); #1;
        req = 1'b0;
        chk("t4_busy_mid", 160'(busy), 160'd1);
        wait_done(1'b0, 900, lat);
        chk("t4_latency", 160'(lat + 11), 160'd768);
        chk("t4_error", 160'(error), 160'h04);
        chk("t4_id_out", 160'(id_out), 160'd0);
        chk("t4_fields", 160'(fields()), 160'd0);
        @(posedge clk); #1;
        chk("t4_no_second_done", 160'(done), 160'd0);
        chk("t4_idle", 160'(busy), 160'd0);

        // Async reset mid-scan
        start_req(1'b1, 8'd0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 160'(busy), 160'd0);
        chk("t6_rden", 160'(ram_rden), 160'd0);
        chk("t6_addr", 160'(ram_addr), 160'd0);
        chk("t6_error", 160'(error), 160'd0);
        chk("t6_id_out", 160'(id_out), 160'd0);
        chk("t6_fields", 160'(fields()), 160'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                if (done !== 1'b0) seen++;
            end
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                if (done !== 1'b0) seen++;
            end
            chk("t6_no_done", 160'(seen), 160'd0);
        end
        mem[5][0] = 1'b1;
        start_req(1'b0, 8'd5);
        wait_done(1'b0, 20, lat);
        chk("t6_after_latency", 160'(lat), 160'd3);
        chk("t6_after_error", 160'(error), 160'h00);
        chk("t6_after_fields", 160'(fields()), 160'(144'hA1B2C3_0D0E0F_C0A80001_C0A80002_0050_04D2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
